gf_root_search: RTL and testbench

GF_ROOT_SEARCH -- requirements
Module: gf_root_search

---
 rtl/gf_pkg.sv | 34 +++
 rtl/gf_poly_eval.sv | 22 ++
 rtl/gf_root_search.sv | 116 +++++++++++
 tb/tb_gf_root_search.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/gf_pkg.sv
// Shared GF(2^8) constants, search FSM states and the field multiplier.
package gf_pkg;

    localparam int M_DEF    = 255;
    localparam int SIZE_DEF = $clog2(M_DEF);

    localparam logic [SIZE_DEF:0]   PRIM_POLY = 9'h11D;
    localparam logic [SIZE_DEF-1:0] ALPHA     = 8'h02;

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        DRAIN,
        DONE
    } state_t;

    // Shift-and-add multiply, reducing by the primitive polynomial each step.
    function automatic logic [SIZE_DEF-1:0] gf_mul(
        input logic [SIZE_DEF-1:0] a,
        input logic [SIZE_DEF-1:0] b
    );
        logic [SIZE_DEF-1:0] aa;
        logic [SIZE_DEF-1:0] r;
        aa = a;
        r  = '0;
        for (int i = 0; i < SIZE_DEF; i++) begin
            if (b[i]) r = r ^ aa;
            aa = {aa[SIZE_DEF-2:0], 1'b0}
               ^ (aa[SIZE_DEF-1] ? PRIM_POLY[SIZE_DEF-1:0] : '0);
        end
        return r;
    endfunction

endpackage

// File: rtl/gf_poly_eval.sv
// Combinational Horner evaluation of a degree-n polynomial over GF(2^SIZE).
module gf_poly_eval
    import gf_pkg::*;
#(
    parameter int n         = 2,
    parameter int m         = M_DEF,
    parameter int SIZE      = $clog2(m),
    parameter int flat_size = (n + 1) * SIZE
) (
    input  logic [flat_size-1:0] p,
    input  logic [SIZE-1:0]      x,
    output logic [SIZE-1:0]      y
);

    always_comb begin
        y = p[n*SIZE +: SIZE];
        for (int i = n - 1; i >= 0; i--) begin
            y = gf_mul(y, x) ^ p[i*SIZE +: SIZE];
        end
    end

endmodule

// File: rtl/gf_root_search.sv
// Chien-style root search: walks x = alpha^0..alpha^(m-1), emits zeros in order.
module gf_root_search
    import gf_pkg::*;
#(
    parameter int m         = M_DEF,
    parameter int SIZE      = $clog2(m),
    parameter int n         = 2,
    parameter int flat_size = (n + 1) * SIZE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [flat_size-1:0] flat_p,
    output logic                 busy,
    output logic                 done,
    output logic                 root_valid,
    input  logic                 root_ready,
    output logic [SIZE-1:0]      root_x,
    output logic [SIZE-1:0]      root_idx,
    output logic [SIZE-1:0]      root_cnt,
    output logic                 zero_poly
);

    state_t state, state_nx;

    logic [flat_size-1:0] p_reg;
    logic [SIZE-1:0]      x_reg;
    logic [SIZE-1:0]      idx;
    logic [SIZE-1:0]      y;

    logic p_zero, hit, load, stall, adv, last, rv_nx;

    gf_poly_eval #(
        .n    (n),
        .m    (m),
        .SIZE (SIZE)
    ) u_eval (
        .p (p_reg),
        .x (x_reg),
        .y (y)
    );

    assign p_zero = (p_reg == '0);
    assign hit    = (state == EVAL) && !p_zero && (y == '0);
    assign load   = hit && (!root_valid || root_ready);
    assign stall  = hit && !load;
    assign adv    = (state == EVAL) && !p_zero && !stall;
    assign last   = (idx == SIZE'(m - 1));
    assign rv_nx  = load || (root_valid && !root_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nx = EVAL;
            end
            EVAL: begin
                busy = 1'b1;
                if (p_zero)
                    state_nx = DONE;
                else if (adv && last)
                    // skip DRAIN when nothing will be left in the output register
                    state_nx = rv_nx ? DRAIN : DONE;
            end
            DRAIN: begin
                busy = 1'b1;
                if (!root_valid || root_ready) state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_reg      <= '0;
            x_reg      <= '0;
            idx        <= '0;
            root_valid <= 1'b0;
            root_x     <= '0;
            root_idx   <= '0;
            root_cnt   <= '0;
            zero_poly  <= 1'b0;
        end else begin
            root_valid <= rv_nx;
            if (state == IDLE && start) begin
                p_reg     <= flat_p;
                x_reg     <= SIZE'(1);
                idx       <= '0;
                root_cnt  <= '0;
                zero_poly <= 1'b0;
            end
            if (state == EVAL && p_zero) zero_poly <= 1'b1;
            if (adv) begin
                x_reg <= gf_mul(x_reg, ALPHA);
                idx   <= idx + SIZE'(1);
            end
            if (load) begin
                root_x   <= x_reg;
                root_idx <= idx;
                root_cnt <= root_cnt + SIZE'(1);
            end
        end
    end

endmodule

// File: tb/tb_gf_root_search.sv
// Random and directed root-search bench with a log/antilog table reference model.
module tb_gf_root_search;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [23:0] flat_p;
    logic        busy;
    logic        done;
    logic        root_valid;
    logic        root_ready;
    logic [7:0]  root_x;
    logic [7:0]  root_idx;
    logic [7:0]  root_cnt;
    logic        zero_poly;

    gf_root_search dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .flat_p     (flat_p),
        .busy       (busy),
        .done       (done),
        .root_valid (root_valid),
        .root_ready (root_ready),
        .root_x     (root_x),
        .root_idx   (root_idx),
        .root_cnt   (root_cnt),
        .zero_poly  (zero_poly)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int sb[$];
    int exp_t[0:255];
    int log_t[0:255];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int gmul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return exp_t[(log_t[a] + log_t[b]) % 255];
    endfunction

    // Brute-force every field element; queue the roots in exponent order.
    task automatic model(input logic [23:0] p, output int cnt, output int lastr);
        int p0, p1, p2, x, v;
        p0 = int'(p[7:0]);
        p1 = int'(p[15:8]);
        p2 = int'(p[23:16]);
        cnt = 0;
        lastr = -1;
        if (p == 24'h0) return;
        for (int i = 0; i < 255; i++) begin
            x = exp_t[i];
            v = p0 ^ gmul(p1, x) ^ gmul(p2, gmul(x, x));
            if (v == 0) begin
                sb.push_back((x << 8) | i);
                cnt++;
                lastr = i;
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && root_valid && root_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL root_unexpected: got x=%0d idx=%0d, expected none",
                         root_x, root_idx);
            end else begin
                int e;
                e = sb.pop_front();
                check("root_x", int'(root_x), (e >> 8) & 255);
                check("root_idx", int'(root_idx), e & 255);
            end
        end
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_root_valid"}, int'(root_valid), 0);
        check({tag, "_root_x"}, int'(root_x), 0);
        check({tag, "_root_idx"}, int'(root_idx), 0);
        check({tag, "_root_cnt"}, int'(root_cnt), 0);
        check({tag, "_zero_poly"}, int'(zero_poly), 0);
    endtask

    // mode 0: ready high, 1: ready from cycle 20, 2: random ready
    task automatic run(input string tag, input logic [23:0] p, input int mode,
                       input int exp_done, input int glitch_at, input int rst_at);
        int cnt, lastr, k;
        bit saw_done, saw_rv;
        model(p, cnt, lastr);
        if (exp_done == -2) exp_done = 256 + ((lastr == 254) ? 1 : 0);
        @(posedge clk); #1;
        flat_p = p;
        start  = 1'b1;
        root_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : 1'($urandom);
        k = 0;
        while (1) begin
            @(posedge clk); #1;
            k++;
            start = (k == glitch_at);
            flat_p = (k == glitch_at) ? 24'h01_03_02 ^ p ^ 24'h00_00_11
                                      : 24'($urandom);
            root_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (k >= 20)
                                             : 1'($urandom);
            if (k == 1) check({tag, "_busy_c1"}, int'(busy), 1);
            if (k == rst_at) begin
                rst_n = 1'b0;
                #1;
                check_reset_state({tag, "_async_rst"});
                sb.delete();
                start = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                rst_n = 1'b1;
                saw_done = 0;
                saw_rv = 0;
                repeat (300) begin
                    @(negedge clk);
                    if (done) saw_done = 1;
                    if (root_valid) saw_rv = 1;
                end
                check({tag, "_no_done_after_rst"}, int'(saw_done), 0);
                check({tag, "_no_root_after_rst"}, int'(saw_rv), 0);
                return;
            end
            if (done) break;
            if (k >= 3000) begin
                check({tag, "_done_timeout"}, k, exp_done);
                start = 1'b0;
                return;
            end
        end
        if (exp_done >= 0) check({tag, "_done_cycle"}, k, exp_done);
        check({tag, "_root_cnt"}, int'(root_cnt), cnt);
        check({tag, "_zero_poly"}, int'(zero_poly), (p == 24'h0) ? 1 : 0);
        check({tag, "_busy_at_done"}, int'(busy), 0);
        check({tag, "_rv_at_done"}, int'(root_valid), 0);
        check({tag, "_sb_empty"}, sb.size(), 0);
        start = 1'b0;
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, int'(done), 0);
        sb.delete();
    endtask

    initial begin
        int e;
        e = 1;
        for (int i = 0; i < 255; i++) begin
            exp_t[i] = e;
            log_t[e] = i;
            e = e << 1;
            if (e & 256) e = e ^ 285;
        end
        rst_n = 1'b0;
        start = 1'b0;
        flat_p = '0;
        root_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst_n = 1'b1;

        run("two_roots", 24'h01_03_02, 0, 256, -1, -1);
        run("backpress", 24'h01_03_02, 1, 274, -1, -1);
        run("zero_poly", 24'h00_00_00, 0, 2, -1, -1);
        run("no_roots", 24'h00_00_05, 0, 256, -1, -1);
        run("start_busy", 24'h01_03_02, 0, 256, 50, -1);
        run("mid_reset", 24'h01_03_02, 0, 256, -1, 100);
        run("after_rst", 24'h01_03_02, 0, 256, -1, -1);
        // x = alpha^254 is a root: last-cycle load has to pass through DRAIN
        run("last_root", {8'h01, 8'(exp_t[254]), 8'h00}, 0, -2, -1, -1);

        for (int t = 0; t < 8; t++) begin
            logic [23:0] p;
            int a, b, c;
            if (t % 2 == 0) begin
                a = exp_t[$urandom_range(0, 254)];
                b = exp_t[$urandom_range(0, 254)];
                c = $urandom_range(1, 255);
                p = {8'(c), 8'(gmul(c, a ^ b)), 8'(gmul(c, gmul(a, b)))};
            end else begin
                p = 24'($urandom);
            end
            if (t < 4) run("rand_rdy1", p, 0, -2, -1, -1);
            else       run("rand_rdyx", p, 2, -1, -1, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1);
    end

endmodule
